// File: rtl/memory_access_arbiter.sv
// Two-port (instruction fetch / data) arbiter and setup-access-recover sequencer
// for the 64 x 32 RAM; the only block that drives the RAM's inputs.
module memory_access_arbiter #(
  parameter int ACCESS_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic        F_Req,
  input  logic        D_Req,
  input  logic [5:0]  F_Address,
  input  logic [5:0]  D_Address,
  input  logic        F_Read_H_Write_L,
  input  logic        D_Read_H_Write_L,
  input  logic [31:0] F_WriteData,
  input  logic [31:0] D_WriteData,
  output logic        F_Ack,
  output logic        D_Ack,
  output logic [31:0] ReadData,
  output logic        Error,
  output logic        Busy,
  output logic [6:0]  RamAddress,
  output logic [31:0] RamDataIn,
  output logic        RamRead_H_Write_L,
  input  logic [31:0] RamDataOut,
  input  logic        RamMFC
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  localparam logic [3:0] ACC_MIN = 4'(ACCESS_CYCLES);
  localparam logic [7:0] TMO_MAX = 8'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic        last_d_q;     // 1: D won the previous grant
  logic        win_d_q;      // 1: D owns the current transfer
  logic        rd_q;
  logic [6:0]  ram_addr_q;
  logic [31:0] ram_din_q;
  logic        ram_rw_q;
  logic [31:0] read_data_q;
  logic        f_ack_q;
  logic        d_ack_q;
  logic        err_q;
  logic        busy_q;
  logic [3:0]  acnt_q;
  logic [7:0]  tcnt_q;

  logic grant_d;
  logic mfc_done;
  logic timed_out;

  // Round robin: on a tie the port that did not win last time gets the grant.
  assign grant_d   = D_Req && (!F_Req || !last_d_q);
  assign mfc_done  = (acnt_q >= ACC_MIN) && RamMFC;
  assign timed_out = !mfc_done && (tcnt_q >= TMO_MAX);

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      win_d_q     <= 1'b0;
      rd_q        <= 1'b1;
      ram_addr_q  <= 7'h40;
      ram_din_q   <= '0;
      ram_rw_q    <= 1'b1;
      read_data_q <= '0;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      acnt_q      <= '0;
      tcnt_q      <= '0;
    end else begin
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (F_Req || D_Req) begin
            win_d_q    <= grant_d;
            last_d_q   <= grant_d;
            rd_q       <= grant_d ? D_Read_H_Write_L : F_Read_H_Write_L;
            ram_addr_q <= {1'b1, (grant_d ? D_Address : F_Address)};
            ram_din_q  <= grant_d ? D_WriteData : F_WriteData;
            ram_rw_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          // Address and data have been stable for a cycle; now select.
          ram_addr_q[6] <= 1'b0;
          ram_rw_q      <= rd_q;
          acnt_q        <= 4'd1;
          tcnt_q        <= 8'd1;
          state_q       <= ACCESS;
        end
        ACCESS: begin
          if (mfc_done || timed_out) begin
            ram_addr_q[6] <= 1'b1;
            ram_rw_q      <= 1'b1;
            f_ack_q       <= !win_d_q;
            d_ack_q       <= win_d_q;
            err_q         <= timed_out;
            if (rd_q && mfc_done) begin
              read_data_q <= RamDataOut;
            end
            state_q <= RECOVER;
          end else begin
            if (acnt_q != 4'hF) acnt_q <= acnt_q + 4'd1;
            if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
          end
        end
        RECOVER: begin
          busy_q  <= 1'b0;
          acnt_q  <= '0;
          tcnt_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign F_Ack             = f_ack_q;
  assign D_Ack             = d_ack_q;
  assign Error             = err_q;
  assign Busy              = busy_q;
  assign ReadData          = read_data_q;
  assign RamAddress        = ram_addr_q;
  assign RamDataIn         = ram_din_q;
  assign RamRead_H_Write_L = ram_rw_q;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Randomised scoreboard bench for memory_access_arbiter with a RAM model whose
// MFC delay is set per round, plus directed reset / contention / timeout cases.
module tb_memory_access_arbiter;

  localparam int ACC = 1;
  localparam int TMO = 16;

  logic        Clock = 1'b0;
  logic        Reset_L = 1'b0;
  logic        F_Req = 1'b0, D_Req = 1'b0;
  logic [5:0]  F_Address = '0, D_Address = '0;
  logic        F_Read_H_Write_L = 1'b1, D_Read_H_Write_L = 1'b1;
  logic [31:0] F_WriteData = '0, D_WriteData = '0;
  logic        F_Ack, D_Ack, Error, Busy, RamRead_H_Write_L, RamMFC;
  logic [31:0] ReadData, RamDataIn, RamDataOut;
  logic [6:0]  RamAddress;

  memory_access_arbiter #(.ACCESS_CYCLES(ACC), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock(Clock), .Reset_L(Reset_L),
    .F_Req(F_Req), .D_Req(D_Req),
    .F_Address(F_Address), .D_Address(D_Address),
    .F_Read_H_Write_L(F_Read_H_Write_L), .D_Read_H_Write_L(D_Read_H_Write_L),
    .F_WriteData(F_WriteData), .D_WriteData(D_WriteData),
    .F_Ack(F_Ack), .D_Ack(D_Ack), .ReadData(ReadData), .Error(Error), .Busy(Busy),
    .RamAddress(RamAddress), .RamDataIn(RamDataIn),
    .RamRead_H_Write_L(RamRead_H_Write_L), .RamDataOut(RamDataOut), .RamMFC(RamMFC)
  );

  always #5 Clock = ~Clock;

  typedef struct { bit rd; logic [5:0] addr; logic [31:0] data; } txn_t;
  typedef struct { bit port_d; bit rd; logic [5:0] addr; bit err;
                   logic [31:0] rdata; int lat; int rwlow; } exp_t;

  txn_t        fpend[$], dpend[$];
  exp_t        sb[$];
  logic [31:0] mem   [64];
  logic [31:0] mem_m [64];
  logic [31:0] last_read = '0;
  bit          last_d = 1'b1;
  bit          init_phase = 1'b1;
  logic [7:0]  dly = '0;
  logic [7:0]  acc_cnt = '0;
  int          cyc = 0;
  int          round_start = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  // RAM model: writes on every selected write cycle, MFC after dly ACCESS cycles.
  always @(posedge Clock) begin
    if (init_phase) mem[cyc[5:0]] <= mem_m[cyc[5:0]];
    else if (!RamAddress[6] && !RamRead_H_Write_L) mem[RamAddress[5:0]] <= RamDataIn;
  end
  always @(posedge Clock) acc_cnt <= RamAddress[6] ? 8'd0 : acc_cnt + 8'd1;
  assign RamDataOut = !RamAddress[6] ? mem[RamAddress[5:0]] : 32'hBAD0BAD0;
  assign RamMFC     = !RamAddress[6] && (acc_cnt >= dly);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every Ack.
  int         rwlow_cnt = 0;
  logic [6:0] rw_addr = '0;
  always @(negedge Clock) begin
    exp_t e;
    if (!Reset_L) begin
      rwlow_cnt = 0;
    end else begin
      if (!RamRead_H_Write_L) begin
        rwlow_cnt++;
        rw_addr = RamAddress;
        chk("rw_low_while_selected", 32'(RamAddress[6]), 32'd0);
      end
      if (F_Ack || D_Ack) begin
        chk("ack_onehot", 32'(F_Ack & D_Ack), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_ack", {30'd0, F_Ack, D_Ack}, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("ack port=%s rd=%0d addr=%0d err=%0d rdata=%h lat=%0d",
                   D_Ack ? "D" : "F", e.rd, e.addr, Error, ReadData, cyc - round_start);
          chk("ack_port", 32'(D_Ack), 32'(e.port_d));
          chk("error", 32'(Error), 32'(e.err));
          chk("read_data", ReadData, e.rdata);
          chk("latency", cyc - round_start, e.lat);
          chk("rw_low_cycles", rwlow_cnt, e.rwlow);
          if (!e.rd) chk("write_addr", 32'(rw_addr), {25'd0, 1'b0, e.addr});
        end
        rwlow_cnt = 0;
      end else if (Error) begin
        chk("stray_error", 32'(Error), 32'd0);
      end
    end
  end

  // Reference model: order grants by round robin and apply them to a plain array.
  task automatic plan_round(input int d);
    txn_t fq[$], dq[$], t;
    int   n, i;
    bit   to, pd;
    to = (d + 1) > TMO;
    n  = to ? TMO : ((d + 1) < ACC ? ACC : d + 1);
    fq = fpend;
    dq = dpend;
    i  = 0;
    while (fq.size() != 0 || dq.size() != 0) begin
      if (fq.size() != 0 && dq.size() != 0) pd = !last_d;
      else pd = (dq.size() != 0);
      last_d = pd;
      t = pd ? dq.pop_front() : fq.pop_front();
      if (!t.rd) mem_m[t.addr] = t.data;
      else if (!to) last_read = mem_m[t.addr];
      sb.push_back('{pd, t.rd, t.addr, to, last_read, (n + 2) + i * (n + 3), t.rd ? 0 : n});
      i++;
    end
  endtask

  task automatic drive();
    F_Req = (fpend.size() != 0);
    if (F_Req) begin
      F_Address = fpend[0].addr; F_Read_H_Write_L = fpend[0].rd; F_WriteData = fpend[0].data;
    end
    D_Req = (dpend.size() != 0);
    if (D_Req) begin
      D_Address = dpend[0].addr; D_Read_H_Write_L = dpend[0].rd; D_WriteData = dpend[0].data;
    end
  endtask

  task automatic run_round(input int d, input int pulse_at);
    bit done;
    plan_round(d);
    dly = 8'(d);
    round_start = cyc;
    drive();
    done = 1'b0;
    for (int it = 1; it <= 600 && !done; it++) begin
      @(negedge Clock);
      if (F_Ack && fpend.size() != 0) void'(fpend.pop_front());
      if (D_Ack && dpend.size() != 0) void'(dpend.pop_front());
      drive();
      if (it == pulse_at) begin
        F_Req = 1'b1;
        F_Address = 6'($urandom);
      end
      done = (fpend.size() == 0 && dpend.size() == 0 && sb.size() == 0);
    end
    if (!done) begin
      chk("round_timeout_pending", sb.size(), 32'd0);
      sb.delete(); fpend.delete(); dpend.delete();
    end
    F_Req = 1'b0;
    D_Req = 1'b0;
    repeat (2) @(negedge Clock);
    chk("idle_after_round", 32'(Busy), 32'd0);
  endtask

  task automatic reset_mid_access();
    bit seen;
    dpend.push_back('{1'b0, 6'd9, 32'hCAFEF00D});
    dly = 8'd10;
    drive();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clock);
      seen = !RamAddress[6];
    end
    chk("reached_access", 32'(seen), 32'd1);
    repeat (2) @(posedge Clock);
    #2 Reset_L = 1'b0;
    #1;
    $display("reset asserted mid-access: addr=%h rw=%0d busy=%0d", RamAddress, RamRead_H_Write_L, Busy);
    chk("rst_ram_address", 32'(RamAddress), 32'h40);
    chk("rst_rw", 32'(RamRead_H_Write_L), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_acks", {30'd0, F_Ack, D_Ack}, 32'd0);
    chk("rst_read_data", ReadData, 32'd0);
    D_Req = 1'b0;
    dpend.delete();
    repeat (2) @(negedge Clock);
    Reset_L = 1'b1;
    repeat (3) @(negedge Clock);
    chk("post_rst_busy", 32'(Busy), 32'd0);
    chk("post_rst_address", 32'(RamAddress), 32'h40);
    mem_m[9]  = 32'hCAFEF00D;  // write landed during the aborted ACCESS cycles
    last_read = '0;
    last_d    = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   dtab[7] = '{0, 0, 1, 2, 3, 6, 40};
    for (int i = 0; i < 64; i++) mem_m[i] = $urandom;
    repeat (70) @(negedge Clock);
    chk("reset_ram_address", 32'(RamAddress), 32'h40);
    chk("reset_rw", 32'(RamRead_H_Write_L), 32'd1);
    chk("reset_data_in", RamDataIn, 32'd0);
    chk("reset_read_data", ReadData, 32'd0);
    chk("reset_busy_ack_err", {29'd0, Busy, F_Ack | D_Ack, Error}, 32'd0);
    init_phase = 1'b0;
    Reset_L = 1'b1;
    @(negedge Clock);

    dpend.push_back('{1'b0, 6'd5, 32'hDEADBEEF});
    run_round(0, -1);
    dpend.push_back('{1'b1, 6'd5, 32'h0});
    run_round(0, -1);
    chk("write_then_read", ReadData, 32'hDEADBEEF);

    reset_mid_access();

    for (int i = 0; i < 2; i++) begin
      fpend.push_back('{1'b0, 6'(10 + i), $urandom});
      dpend.push_back('{1'b1, 6'(10 + i), 32'h0});
    end
    run_round(0, -1);

    dpend.push_back('{1'b1, 6'd63, 32'h0});
    run_round(5, -1);

    fpend.push_back('{1'b1, 6'd2, 32'h0});
    run_round(255, -1);

    dpend.push_back('{1'b0, 6'd20, $urandom});
    run_round(3, 2);

    for (int r = 0; r < 30; r++) begin
      int nf, nd;
      nf = $urandom_range(0, 3);
      nd = $urandom_range(0, 3);
      if (nf + nd == 0) nd = 1;
      for (int i = 0; i < nf + nd; i++) begin
        t.rd   = 1'($urandom_range(0, 1));
        t.addr = 6'($urandom_range(0, 7));
        t.data = $urandom;
        if (i < nf) fpend.push_back(t);
        else dpend.push_back(t);
      end
      run_round(dtab[$urandom_range(0, 6)], -1);
    end

    repeat (5) @(negedge Clock);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
